// File: rtl/leb128_pkg.sv
// Shared LEB128 constants and types for the window buffer and the unpack decoders.
package leb128_pkg;

    localparam int LEB_MAX_BYTES = 10;
    localparam int LEB_BYTE_W    = 8;
    localparam int LEB_WIN_W     = LEB_MAX_BYTES * LEB_BYTE_W;

    typedef logic [LEB_BYTE_W-1:0] leb_byte_t;
    typedef logic [LEB_WIN_W-1:0]  leb_win_t;

endpackage

// File: rtl/leb128_term_detect.sv
// Finds LEB128 terminator bytes (continuation bit clear) among the valid window bytes
// and flags a window of ten or more bytes that contains none.
module leb128_term_detect
    import leb128_pkg::*;
#(
    parameter int CW = 5
) (
    input  leb_win_t                   win,
    input  logic [CW-1:0]              count,
    output logic [LEB_MAX_BYTES-1:0]   term,
    output logic                       any_term,
    output logic                       overlong
);

    // Zero-filled slots have bit 7 clear, so each slot must also be gated by count.
    genvar gi;
    generate
        for (gi = 0; gi < LEB_MAX_BYTES; gi++) begin : g_term
            assign term[gi] = (CW'(gi) < count) && !win[gi*LEB_BYTE_W + LEB_BYTE_W - 1];
        end
    endgenerate

    assign any_term = |term;
    assign overlong = (count >= CW'(LEB_MAX_BYTES)) && !any_term;

endmodule

// File: rtl/leb128_window.sv
// Circular byte buffer presenting the oldest ten bytes as a zero-filled decoder window;
// the consumer pops the decoded length once a complete encoding is visible.
module leb128_window
    import leb128_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [LEB_WIN_W-1:0]  win_data,
    output logic [CW-1:0]         win_count,
    output logic                  win_valid,
    input  logic                  consume_valid,
    input  logic [3:0]            consume_len,
    output logic                  err_overlong,
    output logic                  err_consume
);

    localparam int AW = CW - 1;

    leb_byte_t mem [DEPTH];

    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          err_overlong_reg, err_overlong_next;
    logic          err_consume_reg, err_consume_next;

    logic [LEB_MAX_BYTES-1:0] term;
    logic                     any_term;
    logic                     overlong;
    logic                     push;
    logic                     pop;

    assign in_ready     = (count_reg < CW'(DEPTH)) && !err_overlong_reg;
    assign win_count    = count_reg;
    assign win_valid    = any_term && !err_overlong_reg;
    assign err_overlong = err_overlong_reg;
    assign err_consume  = err_consume_reg;

    // Window slot k reads rd_ptr+k; the pointer width makes the wrap implicit.
    genvar gi;
    generate
        for (gi = 0; gi < LEB_MAX_BYTES; gi++) begin : g_win
            logic [AW-1:0] idx;
            assign idx = rd_ptr_reg + AW'(gi);
            assign win_data[gi*LEB_BYTE_W +: LEB_BYTE_W] =
                (CW'(gi) < count_reg) ? mem[idx] : '0;
        end
    endgenerate

    leb128_term_detect #(
        .CW (CW)
    ) u_term (
        .win      (win_data),
        .count    (count_reg),
        .term     (term),
        .any_term (any_term),
        .overlong (overlong)
    );

    assign push = in_valid && in_ready && !flush;
    assign pop  = consume_valid && win_valid && (consume_len != 4'd0)
               && (consume_len <= 4'(LEB_MAX_BYTES)) && (CW'(consume_len) <= count_reg);

    always_comb begin
        rd_ptr_next       = rd_ptr_reg;
        wr_ptr_next       = wr_ptr_reg;
        count_next        = count_reg;
        err_overlong_next = err_overlong_reg;
        err_consume_next  = 1'b0;
        if (flush) begin
            rd_ptr_next       = '0;
            wr_ptr_next       = '0;
            count_next        = '0;
            err_overlong_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(consume_len);
            end
            count_next = count_reg + CW'(push) - (pop ? CW'(consume_len) : CW'(0));
            if (overlong) begin
                err_overlong_next = 1'b1;
            end
            err_consume_next = consume_valid && !pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            err_overlong_reg <= 1'b0;
            err_consume_reg  <= 1'b0;
        end else begin
            rd_ptr_reg       <= rd_ptr_next;
            wr_ptr_reg       <= wr_ptr_next;
            count_reg        <= count_next;
            err_overlong_reg <= err_overlong_next;
            err_consume_reg  <= err_consume_next;
        end
    end

    // Storage carries no reset; count gates every read so stale bytes stay hidden.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

endmodule

// File: doc/leb128_window.md
Name: leb128_window

Overview:
- Byte-stream buffer directly upstream of the combinational unpack_i64 / unpack_u64 decoders.
- Accepts LEB128-encoded bytes one per cycle over a valid/ready handshake and stores them in a circular buffer.
- Presents the oldest 10 bytes as a window for the decoder. The downstream consumer returns the decoded length, which pops that many bytes.
- Flags encodings that exceed 10 bytes.

Parameters:
- DEPTH, 16, buffer capacity in bytes. Power of two, at least 10.
- CW, 5, width of the byte counter. Equals clog2(DEPTH)+1.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- in_data, input, 8, incoming LEB128 byte.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, buffer can accept a byte this cycle.
- flush, input, 1, synchronous discard of all buffered bytes and errors.
- win_data, output, 80, window. Byte k is at [8k+7:8k] and maps to decoder input i_k.
- win_count, output, CW, bytes currently buffered.
- win_valid, output, 1, window holds a complete encoding.
- consume_valid, input, 1, consumer pops consume_len bytes.
- consume_len, input, 4, bytes to pop, 1..10. Connects to decoder len.
- err_overlong, output, 1, sticky. First 10 bytes have no terminator.
- err_consume, output, 1, one-cycle pulse. Illegal consume was ignored.

Behaviour:
- Reset values:
  - count, rd_ptr, wr_ptr = 0.
  - in_ready = 1, win_valid = 0, win_count = 0, err_overlong = 0, err_consume = 0, win_data = 0.
  - Buffer storage is not reset.
- Push:
  - Occurs when in_valid && in_ready && !flush.
  - Byte is written at wr_ptr, and wr_ptr increments mod DEPTH.
- in_ready = (count < DEPTH) && !err_overlong.
  - Registered-state only. There is no combinational path from consume_valid or in_valid.
  - A full buffer does not accept a byte in the same cycle as a pop.
- Window:
  - win_data byte k = buf[(rd_ptr+k) mod DEPTH] when k < count, else 8'h00.
  - Zero fill guarantees that stale bytes never reach the decoder.
  - Combinational from registers only. A byte pushed in cycle N is visible in the window in cycle N+1.
- Terminator detection:
  - term[k] = (k < count) && !win_data[8k+7], for k = 0..9.
  - win_valid = |term && !err_overlong.
- Overlong error:
  - err_overlong sets when count >= 10 and term[9:0] == 0.
  - While set: win_valid = 0 and in_ready = 0.
  - Cleared only by flush or reset.
- Pop:
  - Legal when consume_valid && win_valid && 1 <= consume_len <= 10 && consume_len <= count.
  - Effect: rd_ptr += consume_len mod DEPTH.
  - Any other cycle with consume_valid high is ignored and pulses err_consume for one cycle.
  - The block does not check consume_len against the terminator position. The consumer must supply the decoder's len.
- Count update: count' = count + push - (legal pop ? consume_len : 0). Push and pop in the same cycle are both applied.
- Wrap-around: all pointer arithmetic is mod DEPTH. A window straddling the buffer end is presented contiguously.
- Flush:
  - Next cycle: count = 0, rd_ptr = wr_ptr = 0, err_overlong = 0.
  - Any push or consume in the flush cycle is discarded, and no err_consume is raised.
- Reset mid-operation: asynchronous return to reset values. The contents are lost.

Decomposition:
- Shared package leb128_pkg holds:
  - LEB_MAX_BYTES = 10.
  - LEB_BYTE_W = 8.
  - Window width constant, 80.
  - Typedefs for a LEB byte and the 10-byte window.
  - Shared with unpack_i64 / unpack_u64.
- One natural sub-module: leb128_term_detect.
  - Input: 80-bit window and count.
  - Outputs: term vector, any_term, and overlong flag.
  - Combinational, reusable by a future packed-stream splitter.
- Circular buffer, pointers and counters stay in leb128_window.

Test Plan:
- Push ff×9 then 01, no consume:
  - win_valid = 0 through the 9th byte.
  - One cycle after the 10th push: win_valid = 1, win_count = 10, win_data = {01, ff×9}.
  - Decoder gives o = -1, len = 10. Consume 10, then count = 0 and win_valid = 0.
- Push 80 80 80 80 0c bc 0b:
  - win_valid rises the cycle after 0c is accepted.
  - Bytes 5..9 of win_data read 00 at that point.
  - Decoder gives 32'hc0000000, len = 5. Consume 5, then the window starts at bc and win_count = 2.
- Push 16 bytes of 00 with no consume:
  - in_ready falls when count = 16.
  - A push attempted while full is not accepted.
  - After consume 1, in_ready = 1 the next cycle.
- Push 10×80:
  - err_overlong = 1 and win_valid = 0.
  - in_ready = 0 even though count = 10 < 16.
  - flush clears all three and gives count = 0.
- Wrap and simultaneous traffic:
  - Stream of 7f bytes, consuming 1 per cycle while pushing 1 per cycle, for 40 cycles.
  - count is constant, and the window stays correct across pointer wrap.
  - Then consume_len = 0 and consume_len > count: err_consume pulses, and state is unchanged.
- Reset asserted mid-stream with count = 6: all outputs take their reset values asynchronously, before the next clock edge.
